fsm_stream_arb: RTL

Controller that shares one serial Mealy FSM datapath (single-bit `in`, registered single-bit `out`) among several requesters. Each granted requester's parallel word is flushed, shifted LSB-first into the FSM and the FSM's response bits are collected back into a parallel result. Grants rotate round-robin, and a one-cycle done pulse returns the result tagged with the requester id. It sits between the parallel request sources and the serial FSM instance.

---
 rtl/fsm_stream_pkg.sv | 30 +++
 rtl/fsm_stream_arb_rr_pick.sv | 45 ++++
 rtl/fsm_stream_arb.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/fsm_stream_pkg.sv
// Shared definitions for the serial-FSM stream arbiter: controller state
// encoding and elaboration-time sizing helpers.
package fsm_stream_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FLUSH = 3'd1,
    SHIFT = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Ceiling log2; clog2(1) is 0.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >>> 1;
    end
    return r;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/fsm_stream_arb_rr_pick.sv
// Combinational round-robin picker: the first set request at or after the
// pointer, searching upward and wrapping, wins.
module rr_pick
  import fsm_stream_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] onehot,
  output logic [IDW-1:0]  idx,
  output logic            valid
);

  // cand[k] is the requester index examined at search offset k from ptr.
  logic [IDW-1:0] cand [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_cand
      logic [IDW:0] sum;
      assign sum = {1'b0, ptr} + (IDW+1)'(gi);
      assign cand[gi] = (sum >= (IDW+1)'(NREQ)) ? IDW'(sum - (IDW+1)'(NREQ))
                                                 : sum[IDW-1:0];
    end
  endgenerate

  always_comb begin
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    // Walk from the far end so the nearest offset is the last to assign.
    for (int off = NREQ - 1; off >= 0; off--) begin
      if (req[cand[off]]) begin
        valid = 1'b1;
        idx   = cand[off];
      end
    end
    if (valid) begin
      onehot[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/fsm_stream_arb.sv
// Shares one serial Mealy FSM among NREQ parallel requesters: flush, shift a
// word LSB-first, collect the registered responses, return a tagged result.
module fsm_stream_arb
  import fsm_stream_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int WIDTH     = 8,
  parameter int FLUSH_LEN = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   din,
  output logic [NREQ-1:0]         gnt,
  output logic                    busy,
  output logic                    done,
  output logic [clog2(NREQ)-1:0]  done_id,
  output logic [WIDTH-1:0]        dout,
  output logic                    fsm_in,
  input  logic                    fsm_out
);

  localparam int IDW   = clog2(NREQ);
  localparam int CNT_W = clog2(max2(FLUSH_LEN, WIDTH)) + 1;
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_LEN - 1);
  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [IDW-1:0]   ID_LAST    = IDW'(NREQ - 1);

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] res_reg;
  logic [IDW-1:0]   cur_id_reg;
  logic [IDW-1:0]   ptr_reg;

  logic [NREQ-1:0]  pick_onehot;
  logic [IDW-1:0]   pick_idx;
  logic             pick_valid;
  logic [WIDTH-1:0] din_word [NREQ];
  logic [WIDTH-1:0] res_next;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_din
      assign din_word[gi] = din[gi*WIDTH +: WIDTH];
    end
  endgenerate

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req    (req),
    .ptr    (ptr_reg),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  // Responses enter at the MSB so the first captured bit ends up at bit 0.
  assign res_next = {fsm_out, res_reg[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      shift_reg  <= '0;
      res_reg    <= '0;
      cur_id_reg <= '0;
      ptr_reg    <= '0;
      gnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      done_id    <= '0;
      dout       <= '0;
      fsm_in     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          fsm_in  <= 1'b0;
          cnt_reg <= '0;
          if (pick_valid) begin
            gnt        <= pick_onehot;
            busy       <= 1'b1;
            cur_id_reg <= pick_idx;
            if (FLUSH_LEN == 0) begin
              state_reg <= SHIFT;
              fsm_in    <= din_word[pick_idx][0];
              shift_reg <= din_word[pick_idx] >> 1;
            end else begin
              state_reg <= FLUSH;
              shift_reg <= din_word[pick_idx];
            end
          end
        end

        FLUSH: begin
          fsm_in <= 1'b0;
          if (cnt_reg == FLUSH_LAST) begin
            state_reg <= SHIFT;
            cnt_reg   <= '0;
            fsm_in    <= shift_reg[0];
            shift_reg <= shift_reg >> 1;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end

        SHIFT: begin
          // fsm_out lags fsm_in by a cycle, so SHIFT cycle 0 has nothing to keep.
          if (cnt_reg != '0) begin
            res_reg <= res_next;
          end
          if (cnt_reg == SHIFT_LAST) begin
            state_reg <= DRAIN;
            cnt_reg   <= '0;
            fsm_in    <= 1'b0;
          end else begin
            cnt_reg   <= cnt_reg + CNT_W'(1);
            fsm_in    <= shift_reg[0];
            shift_reg <= shift_reg >> 1;
          end
        end

        DRAIN: begin
          res_reg   <= res_next;
          dout      <= res_next;
          done      <= 1'b1;
          done_id   <= cur_id_reg;
          fsm_in    <= 1'b0;
          cnt_reg   <= '0;
          state_reg <= DONE;
        end

        DONE: begin
          gnt       <= '0;
          busy      <= 1'b0;
          fsm_in    <= 1'b0;
          cnt_reg   <= '0;
          ptr_reg   <= (cur_id_reg == ID_LAST) ? '0 : cur_id_reg + IDW'(1);
          state_reg <= IDLE;
        end

        default: begin
          gnt       <= '0;
          busy      <= 1'b0;
          fsm_in    <= 1'b0;
          cnt_reg   <= '0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule
